// File: rtl/ifetch.sv
// Instruction fetch stage: PC, imem address, IF/ID register, stall/redirect/HALT.
// Optional instruction counter enabled by defining IFETCH_PERF_CNT_EN.
module ifetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b010001,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc_2_id,
    output logic        inst_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {S_RUN, S_HALTED} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        valid_q, valid_d;
    logic        is_halt;

    assign is_halt = (imem_rdata[31:26] == HALT_OPCODE);

    // State and IF/ID register; async reset restores power-on values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_WORD;
            pc_id_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
        end
    end

    // Next state: only an unsquashed, unstalled HALT fetch leaves RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (!redirect_valid && !stall && is_halt)
                    state_d = S_HALTED;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    // Datapath: redirect > stall > fetch; HALTED emits bubbles forever
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q;
        if (state_q == S_HALTED) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
        end else if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
        end else if (!stall) begin
            inst_d  = imem_rdata;
            pc_id_d = pc_q;
            valid_d = 1'b1;
            if (!is_halt)
                pc_d = pc_q + 32'd4;
        end
    end

    // Outputs are straight from registered state
    always_comb begin
        imem_addr  = pc_q;
        inst       = inst_q;
        pc_2_id    = pc_id_q;
        inst_valid = valid_q;
        halted     = (state_q == S_HALTED);
    end

`ifdef IFETCH_PERF_CNT_EN
    logic        load_fire;
    logic [31:0] cnt_q;

    assign load_fire = (state_q == S_RUN) && !redirect_valid && !stall;
    assign fetch_count = cnt_q;

    // Saturating count of valid instructions loaded into IF/ID
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= 32'h0;
        else if (load_fire && (cnt_q != 32'hFFFF_FFFF))
            cnt_q <= cnt_q + 32'd1;
    end
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage: owns the program counter, drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register consumed by the decode stage (`inst`). Handles pipeline stall, branch/jump redirect with flush, and HALT detection that freezes fetch until reset. It produces the `inst` stream the decode stage decodes.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `HALT_OPCODE`, 6'b010001, opcode (inst[31:26]) that halts fetch.
- `NOP_WORD`, 32'h0000_0000, bubble inserted on flush/halt (add r0,r0,r0).

- `clk` in 1: Single clock, rising edge.
- `reset` in 1: Asynchronous, active-low reset.
- `stall` in 1: Hold PC and IF/ID register (hazard from downstream).
- `redirect_valid` in 1: Taken branch/jump this cycle.
- `redirect_pc` in 32: Target byte address; bits [1:0] ignored (forced 00).
- `imem_addr` out 32: Byte address to instruction memory; equals `pc`.
- `imem_rdata` in 32: Instruction word; combinational read of `imem_addr`, valid same cycle.
- `inst` out 32: Registered instruction to decode.
- `pc_2_id` out 32: Registered PC of `inst`.
- `inst_valid` out 1: `inst` is a real instruction (0 for bubbles).
- `halted` out 1: Fetch frozen after HALT.
- `fetch_count` out 32: Count of valid instructions issued (see Configuration).

## Operation
- States: RUN, HALTED. Reset -> RUN.
- Priority per cycle in RUN: reset > redirect_valid > stall > normal fetch.
- Normal fetch (RUN, no stall, no redirect): `inst`<=`imem_rdata`, `pc_2_id`<=`pc`, `inst_valid`<=1, `pc`<=`pc`+4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
- HALT fetched (normal fetch and `imem_rdata[31:26]`==HALT_OPCODE): HALT word issued with `inst_valid`=1 so it drains downstream; `pc` holds; state -> HALTED.
- Stall (no redirect): `pc`, `inst`, `pc_2_id`, `inst_valid` hold; counter holds.
- Redirect: `pc`<={redirect_pc[31:2],2'b00}; `inst`<=NOP_WORD, `inst_valid`<=0 (flush wrong-path word), `pc_2_id` holds. Redirect overrides a simultaneous stall and a simultaneous HALT fetch (HALT squashed, stays RUN).
- HALTED: `pc` frozen, `inst`<=NOP_WORD, `inst_valid`<=0 each cycle, `halted`=1; `stall` and `redirect_valid` ignored. Exit only through reset.
- `imem_addr` = `pc` combinationally.

## Timing
- Reset values: `pc`=RESET_PC (so `imem_addr`=RESET_PC), `inst`=NOP_WORD, `pc_2_id`=0, `inst_valid`=0, `halted`=0, `fetch_count`=0.
- Latency: word at `imem_addr` in cycle N appears on `inst` in cycle N+1.
- Redirect sampled in cycle N: target on `imem_addr` in N+1, its instruction on `inst` in N+2; `inst` in N+1 is a bubble (one-bubble penalty).
- HALT fetched in cycle N: `inst`=HALT and `halted`=1 in N+1; bubbles from N+2.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); fetch restarts at RESET_PC on the first edge after deassertion.

## Configuration
- `IFETCH_PERF_CNT_EN` defined: `fetch_count` increments by 1 on every edge that loads `inst` with `inst_valid`=1 (normal fetches including the HALT word). It saturates at 32'hFFFF_FFFF, and reset clears it.
- Not defined: counter logic absent; `fetch_count` is tied to 32'h0.

## Test plan
- Reset, memory words 0x04000001,0x00221800,... at 0,4,8, no stall -> `imem_addr` 0,4,8; `inst` sequence follows one cycle later with `pc_2_id` 0,4,8 and `inst_valid`=1.
- Stall held 3 cycles at pc=8 -> `imem_addr` stays 8; `inst`/`pc_2_id`=4 held; resumes with word@8 after release.
- `redirect_valid`=1, `redirect_pc`=0x0000_0043 while `stall`=1 -> next `imem_addr`=0x40, `inst`=0 with `inst_valid`=0, then word@0x40.
- Word 0x44000000 (HALT) at 0x10 -> `inst`=0x44000000 valid, `halted`=1, `pc` frozen at 0x10, bubbles after; a redirect afterwards has no effect; reset restores RESET_PC.
- HALT word fetched in the same cycle as a redirect to 0x80 -> HALT squashed, `halted`=0, fetch continues at 0x80.
- With `IFETCH_PERF_CNT_EN`, 5 fetches, 2 stall cycles, 1 redirect -> `fetch_count`=5; without the macro -> 0.
